// File: rtl/tracker_query_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ryuki_datatypes
// Shared types for the tracker query arbiter slice.
//   query_kind_t : point / range query selector carried on req_kind
//   arb_state_t  : arbiter FSM encoding
//   NO_MATCH     : value the history buffer reports for a missing time
// -----------------------------------------------------------------------------
package ryuki_datatypes;

    typedef enum logic {
        QUERY_POINT = 1'b0,
        QUERY_RANGE = 1'b1
    } query_kind_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    localparam int NO_MATCH = -1;

endpackage

// File: rtl/tracker_query_arbiter_if.sv
// -----------------------------------------------------------------------------
// tracker_query_arbiter_if
// Requester-side bus between the stage trackers and the arbiter.
//   req_valid/req_kind/req_arg_a/req_arg_b : per-requester query (master drives)
//   req_ready                             : one-hot accept pulse (slave drives)
//   resp_valid                            : one-hot response pulse (slave drives)
//   resp_time_start/resp_time_end/resp_hit: shared response payload
// -----------------------------------------------------------------------------
interface tracker_query_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_kind;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_arg_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_arg_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_time_start;
    logic [DATA_WIDTH-1:0]         resp_time_end;
    logic                          resp_hit;

    modport master (
        output req_valid, req_kind, req_arg_a, req_arg_b,
        input  req_ready, resp_valid, resp_time_start, resp_time_end, resp_hit
    );

    modport slave (
        input  req_valid, req_kind, req_arg_a, req_arg_b,
        output req_ready, resp_valid, resp_time_start, resp_time_end, resp_hit
    );
endinterface

// File: rtl/tracker_query_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: selects the first set request bit at or
// after ptr_i, wrapping at NUM_REQ.
//   req_i       : request vector
//   ptr_i       : index with highest priority this cycle
//   grant_o     : one-hot grant (zero when nothing requests)
//   grant_idx_o : binary index of the granted requester
//   any_grant_o : at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    // base + off modulo NUM_REQ; both operands are below NUM_REQ so one
    // conditional subtract is enough.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned sum;
        sum = int'(base) + off;
        if (sum >= unsigned'(NUM_REQ)) begin
            sum = sum - unsigned'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [PTR_W-1:0] cand_s;
        cand_s      = {PTR_W{1'b0}};
        grant_idx_o = {PTR_W{1'b0}};
        any_grant_o = |req_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s      = wrap_add(ptr_i, unsigned'(i));
            grant_idx_o = req_i[cand_s] ? cand_s : grant_idx_o;
        end
        grant_o = any_grant_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_o)
                              : {NUM_REQ{1'b0}};
    end

endmodule

// File: rtl/tracker_query_arbiter.sv
// -----------------------------------------------------------------------------
// tracker_query_arbiter
// Shares one signal_tracker history buffer between NUM_REQ stage trackers.
// Grants one query at a time round-robin, drives the buffer query inputs,
// waits TRK_LATENCY cycles and returns the result to the granted requester.
//   clk, rst    : clock, asynchronous active-high reset
//   req_if      : requester bus (slave side)
//   trk_value_o : buffer value_in (point lookback)
//   trk_range_o : buffer range_in, {end, start}
//   trk_time_i  : buffer time_out, {time[1], time[0]}
//   trk_range_i : buffer range_out
// Timing: grant accepted at edge E, req_ready visible cycle T, buffer inputs
// from T+1, response pulse at T+TRK_LATENCY+2.
// -----------------------------------------------------------------------------
module tracker_query_arbiter
    import ryuki_datatypes::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TRK_LATENCY = 1,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    tracker_query_arbiter_if.slave  req_if,
    output logic [DATA_WIDTH-1:0]   trk_value_o,
    output logic [2*DATA_WIDTH-1:0] trk_range_o,
    input  logic [2*DATA_WIDTH-1:0] trk_time_i,
    input  logic                    trk_range_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [2:0] WAIT_INIT = 3'(TRK_LATENCY - 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        gnt_idx_q, gnt_idx_d;
    query_kind_t             kind_q, kind_d;
    logic [DATA_WIDTH-1:0]   arg_a_q, arg_a_d;
    logic [DATA_WIDTH-1:0]   arg_b_q, arg_b_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_start_q, resp_start_d;
    logic [DATA_WIDTH-1:0]   resp_end_q, resp_end_d;
    logic                    resp_hit_q, resp_hit_d;
    logic [DATA_WIDTH-1:0]   trk_value_q, trk_value_d;
    logic [2*DATA_WIDTH-1:0] trk_range_q, trk_range_d;

    logic [NUM_REQ-1:0]      pick_onehot_s;
    logic [PTR_W-1:0]        pick_idx_s;
    logic                    pick_any_s;
    logic [DATA_WIDTH-1:0]   time_first_s;
    logic [DATA_WIDTH-1:0]   time_second_s;

    assign time_first_s  = trk_time_i[DATA_WIDTH-1:0];
    assign time_second_s = trk_time_i[2*DATA_WIDTH-1:DATA_WIDTH];

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i       (req_if.req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (pick_onehot_s),
        .grant_idx_o (pick_idx_s),
        .any_grant_o (pick_any_s)
    );

    // State and datapath registers; reset drops any in-flight query.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= {PTR_W{1'b0}};
            gnt_idx_q    <= {PTR_W{1'b0}};
            kind_q       <= QUERY_POINT;
            arg_a_q      <= {DATA_WIDTH{1'b0}};
            arg_b_q      <= {DATA_WIDTH{1'b0}};
            cnt_q        <= 3'd0;
            req_ready_q  <= {NUM_REQ{1'b0}};
            resp_valid_q <= {NUM_REQ{1'b0}};
            resp_start_q <= {DATA_WIDTH{1'b0}};
            resp_end_q   <= {DATA_WIDTH{1'b0}};
            resp_hit_q   <= 1'b0;
            trk_value_q  <= {DATA_WIDTH{1'b0}};
            trk_range_q  <= {2*DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            kind_q       <= kind_d;
            arg_a_q      <= arg_a_d;
            arg_b_q      <= arg_b_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_start_q <= resp_start_d;
            resp_end_q   <= resp_end_d;
            resp_hit_q   <= resp_hit_d;
            trk_value_q  <= trk_value_d;
            trk_range_q  <= trk_range_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_any_s ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (cnt_q == 3'd0) ? RESPOND : WAIT;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath updates; pulses default low, everything else holds.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        gnt_idx_d    = gnt_idx_q;
        kind_d       = kind_q;
        arg_a_d      = arg_a_q;
        arg_b_d      = arg_b_q;
        cnt_d        = cnt_q;
        req_ready_d  = {NUM_REQ{1'b0}};
        resp_valid_d = {NUM_REQ{1'b0}};
        resp_start_d = resp_start_q;
        resp_end_d   = resp_end_q;
        resp_hit_d   = resp_hit_q;
        trk_value_d  = trk_value_q;
        trk_range_d  = trk_range_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    req_ready_d = pick_onehot_s;
                    gnt_idx_d   = pick_idx_s;
                    kind_d      = query_kind_t'(req_if.req_kind[pick_idx_s]);
                    arg_a_d     = req_if.req_arg_a[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    arg_b_d     = req_if.req_arg_b[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    rr_ptr_d    = (pick_idx_s == LAST_IDX) ? {PTR_W{1'b0}}
                                                           : pick_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
                end else begin
                    req_ready_d = {NUM_REQ{1'b0}};
                end
            end
            ISSUE: begin
                // Only the buffer input for this query kind moves; the other
                // keeps its last value.
                if (kind_q == QUERY_POINT) begin
                    trk_value_d = arg_a_q;
                end else begin
                    trk_range_d = {arg_b_q, arg_a_q};
                end
                cnt_d = WAIT_INIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (kind_q == QUERY_POINT) begin
                        resp_start_d = time_first_s;
                        resp_end_d   = time_second_s;
                        resp_hit_d   = (time_second_s != DATA_WIDTH'(NO_MATCH));
                    end else begin
                        resp_start_d = {DATA_WIDTH{1'b0}};
                        resp_end_d   = {DATA_WIDTH{1'b0}};
                        resp_hit_d   = trk_range_i;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESPOND: begin
                resp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;
            end
            default: begin
                req_ready_d = {NUM_REQ{1'b0}};
            end
        endcase
    end

    assign req_if.req_ready       = req_ready_q;
    assign req_if.resp_valid      = resp_valid_q;
    assign req_if.resp_time_start = resp_start_q;
    assign req_if.resp_time_end   = resp_end_q;
    assign req_if.resp_hit        = resp_hit_q;
    assign trk_value_o            = trk_value_q;
    assign trk_range_o            = trk_range_q;

endmodule

// File: tb/tb_tracker_query_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tracker_query_arbiter
// Directed bench: u_dut with TRK_LATENCY=1 for the functional vectors and
// u_dut3 with TRK_LATENCY=3 for the reset-during-wait scenario. The history
// buffer is modelled as static values driven on trk_time_i / trk_range_i.
// -----------------------------------------------------------------------------
module tb_tracker_query_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b1;
    logic [63:0] trk_time_i = 64'd0;
    logic        trk_range_i = 1'b0;
    logic [31:0] trk_value_o, trk_value_o3;
    logic [63:0] trk_range_o, trk_range_o3;

    int n_checks = 0;
    int n_fail   = 0;

    tracker_query_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();
    tracker_query_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus3 ();

    tracker_query_arbiter #(.NUM_REQ(4), .TRK_LATENCY(1), .DATA_WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_if      (bus.slave),
        .trk_value_o (trk_value_o),
        .trk_range_o (trk_range_o),
        .trk_time_i  (trk_time_i),
        .trk_range_i (trk_range_i)
    );

    tracker_query_arbiter #(.NUM_REQ(4), .TRK_LATENCY(3), .DATA_WIDTH(32)) u_dut3 (
        .clk         (clk),
        .rst         (rst3),
        .req_if      (bus3.slave),
        .trk_value_o (trk_value_o3),
        .trk_range_o (trk_range_o3),
        .trk_time_i  (trk_time_i),
        .trk_range_i (trk_range_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full transaction on u_dut with cycle-exact expectations.
    task automatic run_query(input string tag, input int id, input logic kind,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] buf_time, input logic buf_range,
                             input logic [31:0] exp_start, input logic [31:0] exp_end,
                             input logic exp_hit);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        trk_time_i  = buf_time;
        trk_range_i = buf_range;
        bus.req_kind[id]           = kind;
        bus.req_arg_a[id*32 +: 32] = a;
        bus.req_arg_b[id*32 +: 32] = b;
        bus.req_valid              = oh;
        tick();
        check_eq({tag, " req_ready"}, {60'd0, bus.req_ready}, {60'd0, oh});
        bus.req_valid = 4'b0000;
        tick();
        if (kind == 1'b0) begin
            check_eq({tag, " trk_value_o"}, {32'd0, trk_value_o}, {32'd0, a});
        end else begin
            check_eq({tag, " trk_range_o"}, trk_range_o, {b, a});
        end
        tick();
        check_eq({tag, " resp early"}, {60'd0, bus.resp_valid}, 64'd0);
        tick();
        check_eq({tag, " resp_valid"}, {60'd0, bus.resp_valid}, {60'd0, oh});
        check_eq({tag, " start"}, {32'd0, bus.resp_time_start}, {32'd0, exp_start});
        check_eq({tag, " end"}, {32'd0, bus.resp_time_end}, {32'd0, exp_end});
        check_eq({tag, " hit"}, {63'd0, bus.resp_hit}, {63'd0, exp_hit});
        tick();
        check_eq({tag, " resp pulse ends"}, {60'd0, bus.resp_valid}, 64'd0);
        check_eq({tag, " end stable"}, {32'd0, bus.resp_time_end}, {32'd0, exp_end});
    endtask

    // Wait (bounded) for a nonzero req_ready on u_dut.
    task automatic wait_ready(output logic [3:0] v);
        v = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.req_ready != 4'b0000) begin
                v = bus.req_ready;
                break;
            end
        end
    endtask

    // Wait (bounded) for a nonzero resp_valid on u_dut.
    task automatic wait_resp(output logic [3:0] v);
        v = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.resp_valid != 4'b0000) begin
                v = bus.resp_valid;
                break;
            end
        end
    endtask

    initial begin
        logic [3:0] v;
        int         resp_seen;
        bus.req_valid  = 4'b0000;
        bus.req_kind   = 4'b0000;
        bus.req_arg_a  = 128'd0;
        bus.req_arg_b  = 128'd0;
        bus3.req_valid = 4'b0000;
        bus3.req_kind  = 4'b0000;
        bus3.req_arg_a = 128'd0;
        bus3.req_arg_b = 128'd0;

        repeat (3) tick();
        check_eq("reset req_ready", {60'd0, bus.req_ready}, 64'd0);
        check_eq("reset resp_valid", {60'd0, bus.resp_valid}, 64'd0);
        check_eq("reset resp_time_end", {32'd0, bus.resp_time_end}, 64'd0);
        check_eq("reset resp_hit", {63'd0, bus.resp_hit}, 64'd0);
        check_eq("reset trk_value_o", {32'd0, trk_value_o}, 64'd0);
        check_eq("reset trk_range_o", trk_range_o, 64'd0);
        rst  = 1'b0;
        rst3 = 1'b0;
        tick();

        // Point hit, point miss, range hit; pointer walks 0 -> 2 -> 3 -> 1 -> 0.
        run_query("point", 1, 1'b0, 32'd5, 32'd0, {32'd15, 32'd12}, 1'b0,
                  32'd12, 32'd15, 1'b1);
        run_query("miss", 2, 1'b0, 32'd9, 32'd0, {32'hFFFF_FFFF, 32'd7}, 1'b0,
                  32'd7, 32'hFFFF_FFFF, 1'b0);
        run_query("range", 0, 1'b1, 32'd20, 32'd30, {32'd15, 32'd12}, 1'b1,
                  32'd0, 32'd0, 1'b1);
        check_eq("range keeps trk_value_o", {32'd0, trk_value_o}, {32'd0, 32'd9});
        run_query("range miss", 3, 1'b1, 32'hFFFF_FFFC, 32'd100, {32'd15, 32'd12}, 1'b0,
                  32'd0, 32'd0, 1'b0);
        check_eq("range miss keeps trk_value_o", {32'd0, trk_value_o}, {32'd0, 32'd9});

        // All four requesting continuously from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_kind  = 4'b0000;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ready(v);
            if (k == 5) bus.req_valid = 4'b0000;
            check_eq($sformatf("rr grant %0d", k), {60'd0, v}, {60'd0, 4'b0001 << (k % 4)});
            wait_resp(v);
            check_eq($sformatf("rr resp %0d", k), {60'd0, v}, {60'd0, 4'b0001 << (k % 4)});
        end

        // Pointer now 2; only requesters 0 and 3 -> grant 3 then 0.
        bus.req_valid = 4'b1001;
        wait_ready(v);
        bus.req_valid[3] = 1'b0;
        check_eq("skip grant 3", {60'd0, v}, {60'd0, 4'b1000});
        wait_ready(v);
        bus.req_valid[0] = 1'b0;
        check_eq("skip grant 0", {60'd0, v}, {60'd0, 4'b0001});
        wait_resp(v);
        check_eq("skip resp 0", {60'd0, v}, {60'd0, 4'b0001});

        // TRK_LATENCY=3: reset during WAIT drops the query.
        trk_time_i  = {32'd44, 32'd11};
        bus3.req_kind[1]         = 1'b0;
        bus3.req_arg_a[32 +: 32] = 32'd3;
        bus3.req_valid           = 4'b0010;
        tick();
        check_eq("lat3 req_ready", {60'd0, bus3.req_ready}, {60'd0, 4'b0010});
        bus3.req_valid = 4'b0000;
        tick();
        check_eq("lat3 trk_value_o", {32'd0, trk_value_o3}, {32'd0, 32'd3});
        tick();
        rst3 = 1'b1;
        #1;
        check_eq("lat3 rst trk_value_o", {32'd0, trk_value_o3}, 64'd0);
        check_eq("lat3 rst resp_valid", {60'd0, bus3.resp_valid}, 64'd0);
        tick();
        rst3 = 1'b0;
        resp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus3.resp_valid != 4'b0000) resp_seen++;
        end
        check_eq("lat3 dropped resp", 64'(resp_seen), 64'd0);

        // Fresh request after reset is granted at once and answered at T+5.
        trk_time_i = {32'd33, 32'd22};
        bus3.req_kind[2]         = 1'b0;
        bus3.req_arg_a[64 +: 32] = 32'd8;
        bus3.req_valid           = 4'b0100;
        tick();
        check_eq("lat3 fresh ready", {60'd0, bus3.req_ready}, {60'd0, 4'b0100});
        bus3.req_valid = 4'b0000;
        tick();
        check_eq("lat3 fresh trk_value_o", {32'd0, trk_value_o3}, {32'd0, 32'd8});
        repeat (3) begin
            tick();
            check_eq("lat3 fresh resp early", {60'd0, bus3.resp_valid}, 64'd0);
        end
        tick();
        check_eq("lat3 fresh resp_valid", {60'd0, bus3.resp_valid}, {60'd0, 4'b0100});
        check_eq("lat3 fresh start", {32'd0, bus3.resp_time_start}, {32'd0, 32'd22});
        check_eq("lat3 fresh end", {32'd0, bus3.resp_time_end}, {32'd0, 32'd33});
        check_eq("lat3 fresh hit", {63'd0, bus3.resp_hit}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
